// File: rtl/bnn_pkg.sv
// Shared constants and types for the BNN convolution front end.
// Row widths cover the 28x28 input image and the 12x12 pooled feature map.
package bnn_pkg;
  localparam int DW         = 8;
  localparam int K          = 5;
  localparam int IMG_W      = 28;
  localparam int FMAP_W     = 12;
  localparam int IMG_PIXELS = 784;

  typedef logic [DW-1:0] pixel_t;
endpackage

// File: rtl/window_line_delay.sv
// Enabled DW-wide shift register of depth N with every stage exposed.
// Stage 0 holds the most recent accepted sample, stage N-1 the oldest.
module line_delay #(
  parameter int DW = 8,
  parameter int N  = 112
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [DW-1:0]   din,
  output logic [N*DW-1:0] stages
);
  logic [DW-1:0] sr_reg [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) sr_reg[i] <= '0;
    end else if (en) begin
      sr_reg[0] <= din;
      for (int i = 1; i < N; i++) sr_reg[i] <= sr_reg[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      assign stages[gi*DW +: DW] = sr_reg[gi];
    end
  endgenerate
endmodule

// File: rtl/window.sv
// 5-row sliding-window line buffer: emits a vertical column of the current
// pixel plus the same column from the previous K-1 rows, one clock after accept.
module window
  import bnn_pkg::*;
#(
  parameter int DW = bnn_pkg::DW,
  parameter int K  = bnn_pkg::K,
  parameter int W0 = IMG_W,
  parameter int W1 = FMAP_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   din,
  input  logic            state,
  output logic [K*DW-1:0] taps
);
  localparam int N = (K - 1) * W0;

  logic [N*DW-1:0] sr_flat;
  logic [DW-1:0]   tap_sel [K];
  logic [K*DW-1:0] taps_next;
  logic [K*DW-1:0] taps_reg;

  // The delay line is always sized for the longer row; the short row simply
  // taps earlier stages and leaves the tail as don't-care.
  line_delay #(
    .DW(DW),
    .N (N)
  ) u_line_delay (
    .clk   (clk),
    .rst   (rst),
    .en    (start),
    .din   (din),
    .stages(sr_flat)
  );

  assign tap_sel[0] = din;

  genvar gi;
  generate
    for (gi = 1; gi < K; gi++) begin : g_tap
      // Stage gi*W-1 holds the sample exactly gi rows older than din.
      assign tap_sel[gi] = state ? sr_flat[(gi*W1-1)*DW +: DW]
                                 : sr_flat[(gi*W0-1)*DW +: DW];
    end
    for (gi = 0; gi < K; gi++) begin : g_pack
      assign taps_next[gi*DW +: DW] = tap_sel[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      taps_reg <= '0;
    end else if (start) begin
      taps_reg <= taps_next;
    end
  end

  assign taps = taps_reg;
endmodule

// File: tb/tb_window.sv
// Directed self-checking bench for the window line buffer.
// Each task drives its own scenario and compares taps against hand-derived columns.
module tb_window;
  import bnn_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  din;
  logic        state;
  logic [39:0] taps;

  int tests_run;
  int tests_failed;

  window dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .din  (din),
    .state(state),
    .taps (taps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one pixel on the next rising edge; afterwards start is dropped and
  // din is driven to X so only the accepting edge can see a defined value.
  task automatic feed(input logic [7:0] v);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    din   = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    din   = 'x;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst = 1'b1; start = 1'b1; din = 8'hFF;
      @(posedge clk);
      #1;
      tests_run++;
      $display("[TB] reset cycle %0d taps=%h", c, taps);
      if (taps !== 40'h0) begin
        $display("FAIL reset_hold: taps=%h expected=%h", taps, 40'h0);
        tests_failed++;
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst = 1'b0; start = 1'b0; din = 8'hA5;
      @(posedge clk);
      #1;
      tests_run++;
      $display("[TB] post-reset idle %0d taps=%h", c, taps);
      if (taps !== 40'h0) begin
        $display("FAIL reset_idle: taps=%h expected=%h", taps, 40'h0);
        tests_failed++;
      end
    end
  endtask

  // Feeds 0..112 in image mode and checks the n=28 and n=112 columns.
  task automatic image_fill_checks(input string tag);
    for (int n = 0; n <= 112; n++) begin
      feed(8'(n));
      if (n == 28) begin
        tests_run++;
        $display("[TB] %s n=28 taps=%h", tag, taps);
        if (taps !== {8'd0, 8'd0, 8'd0, 8'd0, 8'd28}) begin
          $display("FAIL %s_n28: taps=%h expected=%h", tag, taps, {8'd0, 8'd0, 8'd0, 8'd0, 8'd28});
          tests_failed++;
        end
      end
    end
    tests_run++;
    $display("[TB] %s n=112 taps=%h", tag, taps);
    if (taps !== {8'd0, 8'd28, 8'd56, 8'd84, 8'd112}) begin
      $display("FAIL %s_n112: taps=%h expected=%h", tag, taps, {8'd0, 8'd28, 8'd56, 8'd84, 8'd112});
      tests_failed++;
    end
  endtask

  task automatic test_image_fill();
    do_reset();
    state = 1'b0;
    image_fill_checks("image_fill");
  endtask

  // Switching to the short geometry keeps the buffer: after 0..112 the
  // stage holding x[m] is stage 112-m, so the next pixel 113 sees 65/77/89/101.
  task automatic test_state_switch();
    @(negedge clk);
    state = 1'b1; start = 1'b0; din = 8'h33;
    @(posedge clk);
    #1;
    tests_run++;
    $display("[TB] state switch hold taps=%h", taps);
    if (taps !== {8'd0, 8'd28, 8'd56, 8'd84, 8'd112}) begin
      $display("FAIL switch_hold: taps=%h expected=%h", taps, {8'd0, 8'd28, 8'd56, 8'd84, 8'd112});
      tests_failed++;
    end
    feed(8'd113);
    tests_run++;
    $display("[TB] state switch n=113 taps=%h", taps);
    if (taps !== {8'd65, 8'd77, 8'd89, 8'd101, 8'd113}) begin
      $display("FAIL switch_accept: taps=%h expected=%h", taps, {8'd65, 8'd77, 8'd89, 8'd101, 8'd113});
      tests_failed++;
    end
    state = 1'b0;
  endtask

  task automatic test_fmap();
    do_reset();
    state = 1'b1;
    for (int n = 0; n <= 48; n++) begin
      feed(8'(n));
      if (n == 12) begin
        tests_run++;
        $display("[TB] fmap n=12 taps=%h", taps);
        if (taps !== {8'd0, 8'd0, 8'd0, 8'd0, 8'd12}) begin
          $display("FAIL fmap_n12: taps=%h expected=%h", taps, {8'd0, 8'd0, 8'd0, 8'd0, 8'd12});
          tests_failed++;
        end
      end
    end
    tests_run++;
    $display("[TB] fmap n=48 taps=%h", taps);
    if (taps !== {8'd0, 8'd12, 8'd24, 8'd36, 8'd48}) begin
      $display("FAIL fmap_n48: taps=%h expected=%h", taps, {8'd0, 8'd12, 8'd24, 8'd36, 8'd48});
      tests_failed++;
    end
    state = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    state = 1'b0;
    for (int n = 0; n <= 60; n++) feed(8'(n));
    tests_run++;
    $display("[TB] stall n=60 taps=%h", taps);
    if (taps !== {8'd0, 8'd0, 8'd4, 8'd32, 8'd60}) begin
      $display("FAIL stall_n60: taps=%h expected=%h", taps, {8'd0, 8'd0, 8'd4, 8'd32, 8'd60});
      tests_failed++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      din   = (c == 2) ? 8'hxx : 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      tests_run++;
      $display("[TB] stall cycle %0d taps=%h", c, taps);
      if (taps !== {8'd0, 8'd0, 8'd4, 8'd32, 8'd60}) begin
        $display("FAIL stall_frozen_%0d: taps=%h expected=%h", c, taps, {8'd0, 8'd0, 8'd4, 8'd32, 8'd60});
        tests_failed++;
      end
    end
    feed(8'd61);
    tests_run++;
    $display("[TB] stall resume n=61 taps=%h", taps);
    if (taps !== {8'd0, 8'd0, 8'd5, 8'd33, 8'd61}) begin
      $display("FAIL stall_resume: taps=%h expected=%h", taps, {8'd0, 8'd0, 8'd5, 8'd33, 8'd61});
      tests_failed++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    state = 1'b0;
    for (int n = 0; n <= 100; n++) feed(8'(n) ^ 8'h5A);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; din = 8'hEE;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    tests_run++;
    $display("[TB] mid reset taps=%h", taps);
    if (taps !== 40'h0) begin
      $display("FAIL mid_reset_clear: taps=%h expected=%h", taps, 40'h0);
      tests_failed++;
    end
    image_fill_checks("mid_reset");
  endtask

  task automatic test_full_frame();
    logic [7:0]  x [IMG_PIXELS];
    logic [39:0] exp;
    int          bad;
    bad = 0;
    for (int n = 0; n < IMG_PIXELS; n++) x[n] = 8'($urandom_range(0, 255));
    do_reset();
    state = 1'b0;
    for (int n = 0; n < IMG_PIXELS; n++) begin
      feed(x[n]);
      exp = '0;
      for (int k = 0; k < 5; k++) begin
        if (n - k * IMG_W >= 0) exp[k*8 +: 8] = x[n - k * IMG_W];
      end
      tests_run++;
      if (taps !== exp) begin
        $display("FAIL full_frame n=%0d: taps=%h expected=%h", n, taps, exp);
        tests_failed++;
        bad++;
      end
    end
    $display("[TB] full frame %0d pixels, %0d column errors", IMG_PIXELS, bad);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b0;
    start = 1'b0;
    din   = 8'h00;
    state = 1'b0;
    test_reset();
    test_image_fill();
    test_state_switch();
    test_fmap();
    test_stall();
    test_mid_reset();
    test_full_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
